// File: rtl/prog_loader.sv
// Program loader and run controller. Streams a header/payload word protocol into
// the core's instruction memory, data memory and register file. It then releases
// the core for a programmable cycle budget and reports when that budget is spent.
module prog_loader #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  localparam int unsigned DAW       = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            imem_we,
  output logic [31:0]     imem_addr,
  output logic [31:0]     imem_wdata,
  output logic            dmem_we,
  output logic [DAW-1:0]  dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            rf_we,
  output logic [4:0]      rf_addr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            core_run,
  output logic            done,
  output logic            err,
  output logic [31:0]     cycle_count
);

  typedef enum logic [2:0] {StIdle, StLoadLo, StLoadHi, StRun, StDone, StErr} state_e;

  localparam logic [1:0] TgtImem  = 2'b00;
  localparam logic [1:0] TgtDmem  = 2'b01;
  localparam logic [1:0] TgtRf    = 2'b10;
  localparam logic [1:0] TgtStart = 2'b11;

  state_e          state_q, state_d;
  logic            ready_en_q;
  logic [1:0]      tgt_q, tgt_d;
  logic [15:0]     idx_q, idx_d;
  logic [13:0]     rem_q, rem_d;
  logic [31:0]     lo_q, lo_d;
  logic [29:0]     budget_q, budget_d;
  logic [31:0]     cycle_q, cycle_d;

  logic            imem_we_d, dmem_we_d, rf_we_d;
  logic [31:0]     imem_addr_d, imem_wdata_d;
  logic [DAW-1:0]  dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_d, rf_wdata_d;
  logic [4:0]      rf_addr_d;

  logic            xfer;
  logic [16:0]     hdr_end;
  logic [16:0]     hdr_limit;
  logic            wr_x;
  logic [XLEN-1:0] wdata_x;

  // Handshake and status decode straight from the state register.
  always_comb begin
    in_ready = ready_en_q &&
               (state_q == StIdle || state_q == StLoadLo ||
                state_q == StLoadHi || state_q == StDone);
    core_run = (state_q == StRun);
    done     = (state_q == StDone);
    err      = (state_q == StErr);
  end

  assign xfer        = in_valid && in_ready;
  assign cycle_count = cycle_q;

  // Range check of a load header: one past the last index must not exceed the depth.
  always_comb begin
    hdr_end = {1'b0, in_data[15:0]} + {3'b000, in_data[29:16]};
    unique case (in_data[31:30])
      TgtImem: hdr_limit = 17'(IMEM_WORDS);
      TgtDmem: hdr_limit = 17'(DMEM_WORDS);
      default: hdr_limit = 17'd32;
    endcase
  end

  // Next-state, write-port and run-counter logic.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    lo_d         = lo_q;
    budget_d     = budget_q;
    cycle_d      = cycle_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr;
    rf_wdata_d   = rf_wdata;
    wr_x         = 1'b0;
    wdata_x      = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (xfer) begin
          if (in_data[31:30] == TgtStart) begin
            budget_d = in_data[29:0];
            cycle_d  = '0;
            state_d  = StRun;
          end else if (in_data[29:16] == 14'd0) begin
            state_d = StIdle;
          end else if (hdr_end > hdr_limit) begin
            state_d = StErr;
          end else begin
            tgt_d   = in_data[31:30];
            idx_d   = in_data[15:0];
            rem_d   = in_data[29:16];
            state_d = StLoadLo;
          end
        end
      end
      StLoadLo: begin
        if (xfer) begin
          if (tgt_q == TgtImem) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = 32'({idx_q, 2'b00});
            imem_wdata_d = in_data;
            idx_d        = idx_q + 16'd1;
            rem_d        = rem_q - 14'd1;
            state_d      = (rem_q == 14'd1) ? StIdle : StLoadLo;
          end else if (XLEN == 32) begin
            wr_x    = 1'b1;
            wdata_x = XLEN'(in_data);
          end else begin
            lo_d    = in_data;
            state_d = StLoadHi;
          end
        end
      end
      StLoadHi: begin
        if (xfer) begin
          wr_x    = 1'b1;
          wdata_x = XLEN'({in_data, lo_q});
        end
      end
      StRun: begin
        cycle_d = cycle_q + 32'd1;
        if (budget_q != 30'd0 && cycle_q == {2'b00, budget_q} - 32'd1) begin
          state_d = StDone;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: state_d = StIdle;
    endcase

    // Completion of a full XLEN entry for DMEM or the register file.
    if (wr_x) begin
      if (tgt_q == TgtDmem) begin
        dmem_we_d    = 1'b1;
        dmem_addr_d  = idx_q[DAW-1:0];
        dmem_wdata_d = wdata_x;
      end else begin
        // x0 is hardwired; the entry is consumed but never written.
        rf_we_d    = (idx_q[4:0] != 5'd0);
        rf_addr_d  = idx_q[4:0];
        rf_wdata_d = wdata_x;
      end
      idx_d   = idx_q + 16'd1;
      rem_d   = rem_q - 14'd1;
      state_d = (rem_q == 14'd1) ? StIdle : StLoadLo;
    end
  end

  // State and registered write ports; in_ready is held off until the first edge out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ready_en_q <= 1'b0;
      tgt_q      <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      lo_q       <= '0;
      budget_q   <= '0;
      cycle_q    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      tgt_q      <= tgt_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      lo_q       <= lo_d;
      budget_q   <= budget_d;
      cycle_q    <= cycle_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      dmem_we    <= dmem_we_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      rf_we      <= rf_we_d;
      rf_addr    <= rf_addr_d;
      rf_wdata   <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, run budget, gaps, mid-entry reset, overflow.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [63:0] dmem_wdata;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [63:0] rf_wdata;
  logic        core_run;
  logic        done;
  logic        err;
  logic [31:0] cycle_count;

  int vectors;
  int miscompares;

  prog_loader #(.XLEN(64), .IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .core_run   (core_run),
    .done       (done),
    .err        (err),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the word.
  task automatic send(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_no_strobe(input string tag);
    chk(tag, {61'd0, imem_we, dmem_we, rf_we}, 64'd0);
  endtask

  logic [31:0] prog [8];
  int          n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    prog[0] = 32'h0000_3083;  // ld   x1, 0(x0)
    prog[1] = 32'h0000_0133;  // add  x2, x0, x0
    prog[2] = 32'h0080_3183;  // ld   x3, 8(x0)
    prog[3] = 32'h0030_8863;  // beq  x1, x3, +16
    prog[4] = 32'h0011_0133;  // add  x2, x2, x1
    prog[5] = 32'h4030_81B3;  // sub  x3, x1, x3
    prog[6] = 32'hFE00_0AE3;  // beq  x0, x0, -12
    prog[7] = 32'h0020_3823;  // sd   x2, 16(x0)

    in_data  = '0;
    in_valid = 1'b0;
    reset    = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_flags", {61'd0, core_run, done, err}, 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    chk_no_strobe("rst_strobes");
    chk("rst_addrs", {27'd0, imem_addr, dmem_addr, rf_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Count 0 header is a no-op.
    send(32'h0000_0010);
    chk_no_strobe("noop_no_strobe");
    chk("noop_ready", 64'(in_ready), 64'd1);

    // IMEM load, back to back.
    send(32'h0008_0000);
    chk_no_strobe("imem_hdr_no_strobe");
    for (int i = 0; i < 8; i++) begin
      send(prog[i]);
      chk("imem_we", 64'(imem_we), 64'd1);
      chk("imem_addr", 64'(imem_addr), 64'(i * 4));
      chk("imem_wdata", 64'(imem_wdata), 64'(prog[i]));
      chk("imem_only_strobe", {62'd0, dmem_we, rf_we}, 64'd0);
    end
    idle(1);
    chk("imem_we_single_pulse", 64'(imem_we), 64'd0);

    // DMEM load.
    send(32'h4002_0000);
    send(32'd1);
    chk_no_strobe("dmem_lo0_no_strobe");
    send(32'd0);
    chk("dmem_w0", {55'd0, dmem_we, dmem_addr}, {55'd0, 1'b1, 8'd0});
    chk("dmem_w0_data", dmem_wdata, 64'd1);
    send(32'd10);
    chk_no_strobe("dmem_lo1_no_strobe");
    send(32'd0);
    chk("dmem_w1", {55'd0, dmem_we, dmem_addr}, {55'd0, 1'b1, 8'd1});
    chk("dmem_w1_data", dmem_wdata, 64'd10);

    // REGFILE load; x0 entry is consumed but not written.
    send(32'h8003_0000);
    send(32'd7);
    send(32'd0);
    chk_no_strobe("rf_x0_suppressed");
    send(32'd5);
    chk_no_strobe("rf_lo1_no_strobe");
    send(32'd0);
    chk("rf_w1", {58'd0, rf_we, rf_addr}, {58'd0, 1'b1, 5'd1});
    chk("rf_w1_data", rf_wdata, 64'd5);
    send(32'd9);
    send(32'd0);
    chk("rf_w2", {58'd0, rf_we, rf_addr}, {58'd0, 1'b1, 5'd2});
    chk("rf_w2_data", rf_wdata, 64'd9);

    // Run for a budget of 100 cycles.
    send(32'hC000_0064);
    chk("run_core_run_rises", 64'(core_run), 64'd1);
    chk("run_in_ready_low", 64'(in_ready), 64'd0);
    chk("run_count_cleared", 64'(cycle_count), 64'd0);
    n = 0;
    while (core_run && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("run_cycles_high", 64'(n), 64'd100);
    chk("run_done", 64'(done), 64'd1);
    chk("run_cycle_count", 64'(cycle_count), 64'd100);
    chk("done_in_ready", 64'(in_ready), 64'd1);
    idle(3);
    chk("done_count_holds", 64'(cycle_count), 64'd100);
    chk("done_holds", 64'(done), 64'd1);

    // New header clears done; payload arrives with gaps in in_valid.
    send(32'h4001_0005);
    chk("hdr_clears_done", {62'd0, done, core_run}, 64'd0);
    idle(2);
    send(32'h1111_2222);
    idle(3);
    chk_no_strobe("gap_no_strobe");
    send(32'h3333_4444);
    chk("gap_dmem_w", {55'd0, dmem_we, dmem_addr}, {55'd0, 1'b1, 8'd5});
    chk("gap_dmem_data", dmem_wdata, 64'h3333_4444_1111_2222);

    // Reset while in LOAD_HI: entry discarded, outputs return to zero.
    send(32'h4001_0007);
    send(32'h0000_AAAA);
    in_data  = 32'h0000_BBBB;
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk_no_strobe("midrst_no_strobe");
    chk("midrst_dmem_addr", 64'(dmem_addr), 64'd0);
    chk("midrst_dmem_data", dmem_wdata, 64'd0);
    chk("midrst_imem", {imem_addr, imem_wdata}, 64'd0);
    @(posedge clk);
    #1;
    chk_no_strobe("midrst_no_strobe_edge");
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_again", 64'(in_ready), 64'd1);
    chk("midrst_flags", {61'd0, core_run, done, err}, 64'd0);

    // Overflow: start 255, count 2 on a 256-entry IMEM.
    send(32'h0002_00FF);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_in_ready", 64'(in_ready), 64'd0);
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    idle(4);
    chk("ovf_err_sticky", 64'(err), 64'd1);
    chk("ovf_ready_sticky", 64'(in_ready), 64'd0);
    chk_no_strobe("ovf_no_strobe");
    chk("ovf_core_run", 64'(core_run), 64'd0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
